// File: rtl/hamming_error_injector.sv
// hamming_error_injector: seeded noise channel that flips 0, 1 or 2 bits of each codeword.
// Latency: 1 cycle from accept to out_*. The single output stage accepts a new word in the same cycle it hands one on.
// Backpressure: in_ready = !out_valid || out_ready. out_* and the LFSR hold while the output is stalled.
// Ports: clk/rst_n; seed_load/seed_val reseed the LFSR; mode/err_rate pick the flip policy;
//        in_valid/in_ready/in_data form the input stream; out_valid/out_ready/out_data/out_flip_mask/out_nflips
//        form the output stream; cnt_single/cnt_double are saturating counters with cnt_clear.
module hamming_error_injector #(
  parameter int          WIDTH = 16,
  parameter logic [31:0] SEED  = 32'hACE1_2024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             seed_load,
  input  logic [31:0]      seed_val,
  input  logic [1:0]       mode,
  input  logic [7:0]       err_rate,
  input  logic             cnt_clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [WIDTH-1:0] out_flip_mask,
  output logic [1:0]       out_nflips,
  output logic [15:0]      cnt_single,
  output logic [15:0]      cnt_double
);

  localparam logic [31:0] FB_MASK = 32'h8020_0003;
  localparam logic [8:0]  W9      = 9'(WIDTH);
  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [31:0]      lfsr_q, lfsr_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [1:0]       nflips_q, nflips_d;
  logic [15:0]      cnt_single_q, cnt_single_d;
  logic [15:0]      cnt_double_q, cnt_double_d;

  logic             accept;
  logic             xfer;
  logic [8:0]       p1, p2_raw, p2;
  logic [WIDTH-1:0] mask_single, mask_double, mask_sel;
  logic [1:0]       nflips_sel;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign xfer     = out_valid_q && out_ready;

  // Flip positions come from the pre-advance LFSR value. A colliding second
  // position is bumped to the next bit (wrapping) so doubles are always two bits.
  always_comb begin
    p1     = {1'b0, lfsr_q[15:8]} % W9;
    p2_raw = {1'b0, lfsr_q[23:16]} % W9;
    p2     = p2_raw;
    if (p2_raw == p1) begin
      p2 = (p1 == W9 - 9'd1) ? 9'd0 : p1 + 9'd1;
    end
  end

  assign mask_single = ONE << p1;
  assign mask_double = mask_single | (ONE << p2);

  always_comb begin
    mask_sel   = '0;
    nflips_sel = 2'd0;
    case (mode)
      2'd1: begin
        mask_sel   = mask_single;
        nflips_sel = 2'd1;
      end
      2'd2: begin
        mask_sel   = mask_double;
        nflips_sel = 2'd2;
      end
      2'd3: begin
        // err_rate = 0 can never satisfy the strict compare, so it never injects.
        if (lfsr_q[7:0] < err_rate) begin
          if (lfsr_q[31]) begin
            mask_sel   = mask_double;
            nflips_sel = 2'd2;
          end else begin
            mask_sel   = mask_single;
            nflips_sel = 2'd1;
          end
        end
      end
      default: begin
        mask_sel   = '0;
        nflips_sel = 2'd0;
      end
    endcase
  end

  // Reseeding takes priority over the per-word advance; a zero seed would lock
  // the LFSR, so SEED is loaded instead.
  always_comb begin
    lfsr_d = lfsr_q;
    if (seed_load) begin
      lfsr_d = (seed_val == 32'd0) ? SEED : seed_val;
    end else if (accept) begin
      lfsr_d = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? FB_MASK : 32'd0);
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    mask_d      = mask_q;
    nflips_d    = nflips_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = in_data ^ mask_sel;
      mask_d      = mask_sel;
      nflips_d    = nflips_sel;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Counters track words actually handed downstream, not words accepted.
  always_comb begin
    cnt_single_d = cnt_single_q;
    cnt_double_d = cnt_double_q;
    if (cnt_clear) begin
      cnt_single_d = 16'd0;
      cnt_double_d = 16'd0;
    end else if (xfer) begin
      if (nflips_q == 2'd1 && cnt_single_q != 16'hFFFF) cnt_single_d = cnt_single_q + 16'd1;
      if (nflips_q == 2'd2 && cnt_double_q != 16'hFFFF) cnt_double_d = cnt_double_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q       <= SEED;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      mask_q       <= '0;
      nflips_q     <= 2'd0;
      cnt_single_q <= 16'd0;
      cnt_double_q <= 16'd0;
    end else begin
      lfsr_q       <= lfsr_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      mask_q       <= mask_d;
      nflips_q     <= nflips_d;
      cnt_single_q <= cnt_single_d;
      cnt_double_q <= cnt_double_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign out_data      = out_data_q;
  assign out_flip_mask = mask_q;
  assign out_nflips    = nflips_q;
  assign cnt_single    = cnt_single_q;
  assign cnt_double    = cnt_double_q;

endmodule

// File: tb/tb_hamming_error_injector.sv
// tb_hamming_error_injector: checks a 16-bit and a 7-bit hamming_error_injector.
// Each device is compared cycle by cycle against a reference model built from the flip rules.
// Hand-computed vectors and directed sequences cover stalls, reseeding, reset and counter saturation.
module tb_hamming_error_injector;

  localparam logic [31:0] SEED = 32'hACE1_2024;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        seed_load;
  logic [31:0] seed_val;
  logic [1:0]  mode;
  logic [7:0]  err_rate;
  logic        cnt_clear;

  logic        in_valid, out_ready;
  logic [15:0] in_data;
  logic        in_ready16, out_valid16;
  logic [15:0] out_data16, mask16;
  logic [1:0]  nflips16;
  logic [15:0] cs16, cd16;

  logic        in_valid7, out_ready7;
  logic [6:0]  in_data7;
  logic        in_ready7, out_valid7;
  logic [6:0]  out_data7, mask7;
  logic [1:0]  nflips7;
  logic [15:0] cs7, cd7;

  int n_cmp = 0;
  int n_bad = 0;
  logic cyc_chk;

  always #5 clk = ~clk;

  hamming_error_injector #(.WIDTH(16), .SEED(SEED)) dut16 (
    .clk(clk), .rst_n(rst_n), .seed_load(seed_load), .seed_val(seed_val),
    .mode(mode), .err_rate(err_rate), .cnt_clear(cnt_clear),
    .in_valid(in_valid), .in_ready(in_ready16), .in_data(in_data),
    .out_valid(out_valid16), .out_ready(out_ready), .out_data(out_data16),
    .out_flip_mask(mask16), .out_nflips(nflips16),
    .cnt_single(cs16), .cnt_double(cd16));

  hamming_error_injector #(.WIDTH(7), .SEED(SEED)) dut7 (
    .clk(clk), .rst_n(rst_n), .seed_load(seed_load), .seed_val(seed_val),
    .mode(mode), .err_rate(err_rate), .cnt_clear(cnt_clear),
    .in_valid(in_valid7), .in_ready(in_ready7), .in_data(in_data7),
    .out_valid(out_valid7), .out_ready(out_ready7), .out_data(out_data7),
    .out_flip_mask(mask7), .out_nflips(nflips7),
    .cnt_single(cs7), .cnt_double(cd7));

  // ---------------- reference model ----------------
  typedef struct packed {
    logic        v;
    logic [15:0] d;
    logic [15:0] m;
    logic [1:0]  n;
    logic [15:0] cs;
    logic [15:0] cd;
    logic [31:0] l;
  } mstate_t;

  mstate_t m16, m7;

  function automatic int popcount(input logic [15:0] x);
    int c = 0;
    for (int i = 0; i < 16; i++) c += int'(x[i]);
    return c;
  endfunction

  function automatic logic [31:0] lfsr_next(input logic [31:0] l);
    return (l >> 1) ^ (l[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  function automatic logic [15:0] mask_of(input logic [31:0] l, input int w,
                                          input logic [1:0] md, input logic [7:0] er);
    int p1, p2;
    logic [15:0] one, two;
    p1 = int'(l[15:8]) % w;
    p2 = int'(l[23:16]) % w;
    if (p2 == p1) p2 = (p1 + 1) % w;
    one = 16'd1 << p1;
    two = one | (16'd1 << p2);
    case (md)
      2'd0: return 16'h0;
      2'd1: return one;
      2'd2: return two;
      default: begin
        if (int'(l[7:0]) < int'(er)) return l[31] ? two : one;
        return 16'h0;
      end
    endcase
  endfunction

  function automatic mstate_t mreset();
    mstate_t r;
    r = '0;
    r.l = SEED;
    return r;
  endfunction

  function automatic mstate_t mstep(input mstate_t s, input int w, input logic iv,
                                    input logic [15:0] din, input logic ordy);
    mstate_t r;
    logic acc;
    r = s;
    acc = iv && (!s.v || ordy);
    if (cnt_clear) begin
      r.cs = 16'h0;
      r.cd = 16'h0;
    end else if (s.v && ordy) begin
      if (s.n == 2'd1 && s.cs != 16'hFFFF) r.cs = s.cs + 16'd1;
      if (s.n == 2'd2 && s.cd != 16'hFFFF) r.cd = s.cd + 16'd1;
    end
    if (acc) begin
      r.m = mask_of(s.l, w, mode, err_rate);
      r.d = din ^ r.m;
      r.n = 2'(popcount(r.m));
      r.v = 1'b1;
    end else if (ordy) begin
      r.v = 1'b0;
    end
    if (seed_load) r.l = (seed_val == 32'h0) ? SEED : seed_val;
    else if (acc)  r.l = lfsr_next(s.l);
    return r;
  endfunction

  // ---------------- checking ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, want);
    end
  endtask

  task automatic compare_all();
    chk("in_ready16", 32'(in_ready16), 32'(!m16.v || out_ready));
    chk("out_valid16", 32'(out_valid16), 32'(m16.v));
    if (m16.v) begin
      chk("out_data16", 32'(out_data16), 32'(m16.d));
      chk("mask16", 32'(mask16), 32'(m16.m));
      chk("nflips16", 32'(nflips16), 32'(m16.n));
    end
    chk("cnt_single16", 32'(cs16), 32'(m16.cs));
    chk("cnt_double16", 32'(cd16), 32'(m16.cd));
    chk("in_ready7", 32'(in_ready7), 32'(!m7.v || out_ready7));
    chk("out_valid7", 32'(out_valid7), 32'(m7.v));
    if (m7.v) begin
      chk("out_data7", 32'(out_data7), 32'(m7.d));
      chk("mask7", 32'(mask7), 32'(m7.m));
    end
    chk("cnt_double7", 32'(cd7), 32'(m7.cd));
  endtask

  // Called at a falling edge with inputs already set up; returns at the next falling edge.
  task automatic tick();
    if (!rst_n) begin
      m16 = mreset();
      m7  = mreset();
    end else begin
      m16 = mstep(m16, 16, in_valid, in_data, out_ready);
      m7  = mstep(m7, 7, in_valid7, {9'b0, in_data7}, out_ready7);
    end
    @(posedge clk);
    @(negedge clk);
    if (cyc_chk) compare_all();
  endtask

  task automatic clear_counters();
    in_valid  = 1'b0;
    in_valid7 = 1'b0;
    cnt_clear = 1'b1;
    tick();
    cnt_clear = 1'b0;
  endtask

  // ---------------- hand-computed vectors ----------------
  typedef struct packed {
    logic [31:0] seed;
    logic [1:0]  md;
    logic [7:0]  er;
    logic [15:0] din;
    logic [15:0] want_mask;
    logic [15:0] want_data;
    logic [1:0]  want_n;
  } vec_t;

  vec_t vecs [11];
  logic [15:0] fresh [8];

  initial begin
    int errs, singles, doubles, coll;
    logic [31:0] l;
    logic [15:0] held_d, held_m, word_b;

    vecs[0]  = '{32'h0000_0300, 2'd1, 8'h00, 16'h0000, 16'h0008, 16'h0008, 2'd1};
    vecs[1]  = '{32'h0005_0300, 2'd2, 8'h00, 16'hFFFF, 16'h0028, 16'hFFD7, 2'd2};
    vecs[2]  = '{32'h0013_0300, 2'd2, 8'h00, 16'h1234, 16'h0018, 16'h122C, 2'd2};
    vecs[3]  = '{32'h000F_0F00, 2'd2, 8'h00, 16'h0000, 16'h8001, 16'h8001, 2'd2};
    vecs[4]  = '{32'h8005_030F, 2'd3, 8'h10, 16'h0000, 16'h0028, 16'h0028, 2'd2};
    vecs[5]  = '{32'h0005_0310, 2'd3, 8'h10, 16'hABCD, 16'h0000, 16'hABCD, 2'd0};
    vecs[6]  = '{32'h0005_0A01, 2'd3, 8'h10, 16'hFFFF, 16'h0400, 16'hFBFF, 2'd1};
    vecs[7]  = '{32'h1234_5678, 2'd0, 8'h00, 16'h5A5A, 16'h0000, 16'h5A5A, 2'd0};
    vecs[8]  = '{32'h0000_FF00, 2'd1, 8'h00, 16'h0000, 16'h8000, 16'h8000, 2'd1};
    vecs[9]  = '{32'h0000_0000, 2'd1, 8'h00, 16'h0000, 16'h0001, 16'h0001, 2'd1};
    vecs[10] = '{32'h0000_0000, 2'd3, 8'hFF, 16'h0000, 16'h0003, 16'h0003, 2'd2};

    // Mode-1 masks a freshly reset 16-bit device must produce.
    l = SEED;
    for (int i = 0; i < 8; i++) begin
      fresh[i] = mask_of(l, 16, 2'd1, 8'h00);
      l = lfsr_next(l);
    end

    rst_n = 1'b0; seed_load = 1'b0; seed_val = 32'h0; mode = 2'd0; err_rate = 8'h0;
    cnt_clear = 1'b0; in_valid = 1'b0; in_data = 16'h0; out_ready = 1'b1;
    in_valid7 = 1'b0; in_data7 = 7'h0; out_ready7 = 1'b1; cyc_chk = 1'b1;
    m16 = mreset(); m7 = mreset();

    #1;
    chk("rst_out_valid", 32'(out_valid16), 32'h0);
    chk("rst_out_data", 32'(out_data16), 32'h0);
    chk("rst_mask", 32'(mask16), 32'h0);
    chk("rst_nflips", 32'(nflips16), 32'h0);
    chk("rst_cnt_single", 32'(cs16), 32'h0);
    chk("rst_cnt_double", 32'(cd16), 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Table: seed the LFSR so the next word's l is known, then send one word.
    for (int i = 0; i < 11; i++) begin
      mode = vecs[i].md; err_rate = vecs[i].er;
      seed_load = 1'b1; seed_val = vecs[i].seed; in_valid = 1'b0;
      tick();
      seed_load = 1'b0; in_valid = 1'b1; in_data = vecs[i].din;
      tick();
      chk($sformatf("vec%0d_data", i), 32'(out_data16), 32'(vecs[i].want_data));
      chk($sformatf("vec%0d_mask", i), 32'(mask16), 32'(vecs[i].want_mask));
      chk($sformatf("vec%0d_nflips", i), 32'(nflips16), 32'(vecs[i].want_n));
      in_valid = 1'b0;
      tick();
    end

    // Reseed in the same cycle as an accept: that word uses the old value,
    // the following word uses the new seed (p1 = 7).
    mode = 2'd1; in_valid = 1'b1; in_data = 16'h0;
    seed_load = 1'b1; seed_val = 32'h0000_0700;
    tick();
    seed_load = 1'b0;
    tick();
    chk("seed_prio_mask", 32'(mask16), 32'h0080);
    in_valid = 1'b0;
    tick();

    // T1: mode 0 passes data straight through with one cycle latency.
    clear_counters();
    mode = 2'd0;
    for (int i = 0; i < 100; i++) begin
      in_valid = 1'b1; in_data = 16'($urandom);
      tick();
      chk("t1_valid", 32'(out_valid16), 32'h1);
      chk("t1_pass", 32'(out_data16), 32'(in_data));
    end
    in_valid = 1'b0;
    tick();
    chk("t1_cnt_single", 32'(cs16), 32'h0);
    chk("t1_cnt_double", 32'(cd16), 32'h0);

    // T2: seed 1, mode 1, all-zero words.
    seed_load = 1'b1; seed_val = 32'h1;
    clear_counters();
    seed_load = 1'b0; mode = 2'd1;
    for (int i = 0; i < 50; i++) begin
      in_valid = 1'b1; in_data = 16'h0;
      tick();
      chk("t2_one_bit", 32'(popcount(out_data16)), 32'd1);
    end
    in_valid = 1'b0;
    tick();
    chk("t2_cnt_single", 32'(cs16), 32'd50);

    // T3: double flips on the 7-bit device, watching for forced collisions.
    clear_counters();
    mode = 2'd2; coll = 0;
    for (int i = 0; i < 1000; i++) begin
      in_valid7 = 1'b1; in_data7 = 7'($urandom);
      if (int'(m7.l[23:16]) % 7 == int'(m7.l[15:8]) % 7) coll++;
      tick();
      chk("t3_two_bits", 32'(popcount({9'b0, mask7})), 32'd2);
    end
    in_valid7 = 1'b0;
    tick();
    chk("t3_collision_hit", 32'(coll > 0), 32'h1);
    chk("t3_cnt_double7", 32'(cd7), 32'd1000);

    // T4: random mode at both error-rate extremes.
    clear_counters();
    mode = 2'd3; err_rate = 8'h00; errs = 0;
    for (int i = 0; i < 2000; i++) begin
      in_valid = 1'b1; in_data = 16'($urandom);
      tick();
      if (mask16 != 16'h0) errs++;
    end
    in_valid = 1'b0;
    tick();
    chk("t4_rate0_errors", 32'(errs), 32'd0);
    chk("t4_rate0_cnt", 32'(cs16 + cd16), 32'd0);
    clear_counters();
    err_rate = 8'hFF; singles = 0; doubles = 0;
    for (int i = 0; i < 2000; i++) begin
      in_valid = 1'b1; in_data = 16'($urandom);
      tick();
      if (nflips16 == 2'd1) singles++;
      if (nflips16 == 2'd2) doubles++;
    end
    in_valid = 1'b0;
    tick();
    chk("t4_rateFF_mostly", 32'(singles + doubles >= 1950), 32'h1);
    chk("t4_single_seen", 32'(singles > 0), 32'h1);
    chk("t4_double_seen", 32'(doubles > 0), 32'h1);

    // T5: output stalled for 5 cycles with a word waiting.
    mode = 2'd1; out_ready = 1'b1; in_valid = 1'b1; in_data = 16'h1111;
    tick();
    held_d = m16.d; held_m = m16.m;
    out_ready = 1'b0; word_b = 16'h2222; in_data = word_b;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t5_in_ready", 32'(in_ready16), 32'h0);
      chk("t5_hold_data", 32'(out_data16), 32'(held_d));
      chk("t5_hold_mask", 32'(mask16), 32'(held_m));
    end
    out_ready = 1'b1;
    tick();
    chk("t5_next_word", 32'(out_data16 ^ mask16), 32'(word_b));
    in_valid = 1'b0;
    tick();
    chk("t5_no_dup", 32'(out_valid16), 32'h0);

    // Random handshake on both sides.
    err_rate = 8'h80; mode = 2'd3;
    for (int i = 0; i < 400; i++) begin
      in_valid = 1'($urandom); out_ready = 1'($urandom); in_data = 16'($urandom);
      in_valid7 = 1'($urandom); in_data7 = 7'($urandom);
      mode = 2'($urandom);
      tick();
    end
    in_valid = 1'b0; in_valid7 = 1'b0; out_ready = 1'b1;
    tick();

    // Clear wins over an increment in the same cycle.
    mode = 2'd1; in_valid = 1'b1;
    tick();
    tick();
    cnt_clear = 1'b1;
    tick();
    cnt_clear = 1'b0;
    chk("clear_wins", 32'(cs16), 32'h0);

    // T6: reset mid-stream, then the fresh-SEED sequence must repeat.
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("t6_valid_async", 32'(out_valid16), 32'h0);
    chk("t6_cnt_single", 32'(cs16), 32'h0);
    chk("t6_nflips", 32'(nflips16), 32'h0);
    in_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    mode = 2'd1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_data = 16'h0;
      tick();
      chk($sformatf("t6_fresh%0d", i), 32'(mask16), 32'(fresh[i]));
    end
    in_valid = 1'b0;
    tick();

    // Saturation of cnt_double: push past 16'hFFFF transfers.
    clear_counters();
    cyc_chk = 1'b0;
    mode = 2'd2; in_valid = 1'b1;
    for (int i = 0; i < 65537; i++) begin
      in_data = 16'($urandom);
      tick();
    end
    chk("sat_cnt_double", 32'(cd16), 32'hFFFF);
    chk("sat_cnt_single", 32'(cs16), 32'h0);
    cyc_chk = 1'b1;
    tick();
    tick();
    chk("sat_hold", 32'(cd16), 32'hFFFF);
    in_valid = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
